// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory signals of the load/store unit
interface load_store_unit_if #(
   parameter int size = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_store;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic [size-1:0] req_base;
   logic [size-1:0] req_offset;
   logic [size-1:0] req_wdata;
   logic            resp_valid;
   logic [size-1:0] resp_rdata;
   logic            resp_fault;
   logic [size-1:0] mem_address;
   logic            mem_read;
   logic            mem_write;
   logic [size-1:0] mem_write_data;
   logic [size-1:0] mem_read_data;

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_base, req_offset, req_wdata,
      input  mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_address, mem_read, mem_write, mem_write_data
   );

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_base, req_offset, req_wdata,
      output mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_address, mem_read, mem_write, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with sub-word read-modify-write in front of word memory
module load_store_unit #(
   parameter int size    = 32,
   parameter int MemSize = 1024
) (
   input  logic               clk,
   input  logic               reset,
   load_store_unit_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t          state_q;
   logic [1:0]      ea_lo_q;
   logic [1:0]      size_q;
   logic            store_q;
   logic            unsigned_q;
   logic [15:0]     wdata_q;
   logic [size-1:0] mem_address_q;
   logic            mem_read_q;
   logic            mem_write_q;
   logic [size-1:0] mem_write_data_q;
   logic            resp_valid_q;
   logic [size-1:0] resp_rdata_q;
   logic            resp_fault_q;

   logic [size-1:0] ea_d;
   logic            fault_d;
   logic            word_store_d;
   logic [4:0]      sh_byte_d;
   logic [4:0]      sh_half_d;
   logic [size-1:0] rbyte_d;
   logic [size-1:0] rhalf_d;
   logic [size-1:0] load_d;
   logic [size-1:0] mask_d;
   logic [size-1:0] lane_d;
   logic [size-1:0] merge_d;

   assign ea_d         = bus.req_base + bus.req_offset;
   assign word_store_d = bus.req_store && (bus.req_size == 2'b10);

   always_comb begin
      fault_d = 1'b0;
      if (bus.req_size == 2'b11)
         fault_d = 1'b1;
      if ((bus.req_size == 2'b01) && ea_d[0])
         fault_d = 1'b1;
      if ((bus.req_size == 2'b10) && (ea_d[1:0] != 2'b00))
         fault_d = 1'b1;
      if ({2'b00, ea_d[size-1:2]} >= size'(MemSize))
         fault_d = 1'b1;
   end

   // Lane selection uses the latched low address bits of the accepted request.
   assign sh_byte_d = {ea_lo_q, 3'b000};
   assign sh_half_d = {ea_lo_q[1], 4'b0000};
   assign rbyte_d   = bus.mem_read_data >> sh_byte_d;
   assign rhalf_d   = bus.mem_read_data >> sh_half_d;

   always_comb begin
      load_d = bus.mem_read_data;
      case (size_q)
         2'b00:   load_d = unsigned_q ? {{(size-8){1'b0}}, rbyte_d[7:0]}
                                      : {{(size-8){rbyte_d[7]}}, rbyte_d[7:0]};
         2'b01:   load_d = unsigned_q ? {{(size-16){1'b0}}, rhalf_d[15:0]}
                                      : {{(size-16){rhalf_d[15]}}, rhalf_d[15:0]};
         default: load_d = bus.mem_read_data;
      endcase
   end

   assign mask_d  = (size_q == 2'b00) ? (size'(8'hFF) << sh_byte_d) : (size'(16'hFFFF) << sh_half_d);
   assign lane_d  = (size_q == 2'b00) ? ({{(size-8){1'b0}}, wdata_q[7:0]} << sh_byte_d)
                                      : ({{(size-16){1'b0}}, wdata_q} << sh_half_d);
   assign merge_d = (bus.mem_read_data & ~mask_d) | lane_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         ea_lo_q          <= '0;
         size_q           <= '0;
         store_q          <= 1'b0;
         unsigned_q       <= 1'b0;
         wdata_q          <= '0;
         mem_address_q    <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_write_data_q <= '0;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= '0;
         resp_fault_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  ea_lo_q    <= ea_d[1:0];
                  size_q     <= bus.req_size;
                  store_q    <= bus.req_store;
                  unsigned_q <= bus.req_unsigned;
                  wdata_q    <= bus.req_wdata[15:0];
                  if (fault_d) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q          <= ACCESS;
                     mem_address_q    <= {2'b00, ea_d[size-1:2]};
                     mem_read_q       <= 1'b1;
                     mem_write_q      <= word_store_d;
                     mem_write_data_q <= word_store_d ? bus.req_wdata : '0;
                  end
               end
            end
            ACCESS: begin
               if (store_q && (size_q != 2'b10)) begin
                  // Old word is merged straight into the write-data register.
                  state_q          <= WRITE;
                  mem_read_q       <= 1'b0;
                  mem_write_q      <= 1'b1;
                  mem_write_data_q <= merge_d;
               end else begin
                  state_q          <= RESP;
                  mem_address_q    <= '0;
                  mem_read_q       <= 1'b0;
                  mem_write_q      <= 1'b0;
                  mem_write_data_q <= '0;
                  resp_valid_q     <= 1'b1;
                  resp_fault_q     <= 1'b0;
                  resp_rdata_q     <= store_q ? '0 : load_d;
               end
            end
            WRITE: begin
               state_q          <= RESP;
               mem_address_q    <= '0;
               mem_write_q      <= 1'b0;
               mem_write_data_q <= '0;
               resp_valid_q     <= 1'b1;
               resp_fault_q     <= 1'b0;
               resp_rdata_q     <= '0;
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = (state_q == IDLE) && !reset;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.resp_fault     = resp_fault_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_write_data = mem_write_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a byte-array model
module tb_load_store_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.size(32)) bus ();

   load_store_unit #(.size(32), .MemSize(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic [31:0] mem [0:1023];
   logic        bd_we = 1'b0;
   logic [9:0]  bd_addr = '0;
   logic [31:0] bd_data = '0;
   int          wr_count = 0;
   int          rd_cycles = 0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   always @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (bus.mem_write)
         mem[bus.mem_address[9:0]] <= bus.mem_write_data;
      if (bus.mem_write) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= bus.mem_address;
         last_wr_data <= bus.mem_write_data;
      end
      if (bus.mem_read)
         rd_cycles <= rd_cycles + 1;
   end

   assign bus.mem_read_data = mem[bus.mem_address[9:0]];

   logic [7:0] ref_bytes [0:4095];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_fault(input logic [31:0] ea, input logic [1:0] sz);
      int n;
      if (sz == 2'b11) return 1'b1;
      n = 1 << sz;
      if ((ea % n) != 0) return 1'b1;
      if ((ea >> 2) >= 1024) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] ea, input logic [1:0] sz, input logic uns);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++)
         v = v | (32'(ref_bytes[ea[11:0] + i]) << (8 * i));
      if (n < 4 && !uns && v[8*n-1])
         v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
   endfunction

   task automatic ref_store(input logic [31:0] ea, input logic [1:0] sz, input logic [31:0] wdata);
      int n;
      n = 1 << sz;
      for (int i = 0; i < n; i++)
         ref_bytes[ea[11:0] + i] = 8'(wdata >> (8 * i));
   endtask

   task automatic run_req(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] base, input logic [31:0] off, input logic [31:0] wdata,
                          output logic [31:0] rdata_o, output logic fault_o);
      logic [31:0] ea;
      logic        flt;
      int          exp_lat;
      int          lat;
      int          wr0;
      int          rd0;
      logic [31:0] exp_rdata;
      ea        = base + off;
      flt       = ref_fault(ea, sz);
      exp_lat   = flt ? 1 : ((st && sz != 2'b10) ? 3 : 2);
      exp_rdata = (flt || st) ? 32'h0 : ref_load(ea, sz, uns);
      wr0 = wr_count;
      rd0 = rd_cycles;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_store    = st;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_base     = base;
      bus.req_offset   = off;
      bus.req_wdata    = wdata;
      check({tag, ".ready_idle"}, bus.req_ready, 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 8) begin
         check({tag, ".ready_busy"}, bus.req_ready, 0);
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".resp_valid"}, bus.resp_valid, 1);
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, ".fault"}, bus.resp_fault, flt);
      check({tag, ".ready_resp"}, bus.req_ready, 0);
      rdata_o = bus.resp_rdata;
      fault_o = bus.resp_fault;
      @(posedge clk);
      #1;
      check({tag, ".pulse"}, bus.resp_valid, 0);
      check({tag, ".ready_after"}, bus.req_ready, 1);
      check({tag, ".rdata_hold"}, bus.resp_rdata, exp_rdata);
      check({tag, ".reads"}, rd_cycles - rd0, flt ? 0 : 1);
      check({tag, ".writes"}, wr_count - wr0, (!flt && st) ? 1 : 0);
      check({tag, ".idle_bus"}, {bus.mem_read, bus.mem_write, bus.mem_address}, 0);
      if (!flt && st) begin
         ref_store(ea, sz, wdata);
         check({tag, ".wr_addr"}, last_wr_addr, ea >> 2);
         check({tag, ".wr_data"}, last_wr_data, ref_word(int'(ea >> 2)));
         check({tag, ".mem_word"}, mem[ea[11:2]], ref_word(int'(ea >> 2)));
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        ft;
      logic [31:0] w;
      logic [31:0] old;
      logic [31:0] ea;
      int          wr0;
      bus.req_valid    = 1'b0;
      bus.req_store    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_base     = '0;
      bus.req_offset   = '0;
      bus.req_wdata    = '0;

      @(posedge clk);
      #1;
      check("rst.ready", bus.req_ready, 0);
      check("rst.resp", {bus.resp_valid, bus.resp_fault, bus.resp_rdata}, 0);
      check("rst.mem", {bus.mem_read, bus.mem_write, bus.mem_address}, 0);
      check("rst.wdata", bus.mem_write_data, 0);

      for (int i = 0; i < 1024; i++) begin
         w = (i == 5) ? 32'h8899_AABB : $urandom;
         @(negedge clk);
         bd_we   = 1'b1;
         bd_addr = 10'(i);
         bd_data = w;
         for (int b = 0; b < 4; b++)
            ref_bytes[4*i+b] = w[8*b +: 8];
      end
      @(negedge clk);
      bd_we = 1'b0;
      reset = 1'b0;
      #1;
      check("rel.ready", bus.req_ready, 1);

      run_req("lb_s17", 0, 2'b00, 0, 32'h10, 32'h7, 0, rd, ft);
      check("plan.lb_s17", rd, 32'hFFFF_FF88);
      run_req("lbu_16", 0, 2'b00, 1, 32'h16, 32'h0, 0, rd, ft);
      check("plan.lbu_16", rd, 32'h0000_0099);
      run_req("lh_s14", 0, 2'b01, 0, 32'h14, 32'h0, 0, rd, ft);
      check("plan.lh_s14", rd, 32'hFFFF_AABB);
      run_req("lhu_16", 0, 2'b01, 1, 32'h16, 32'h0, 0, rd, ft);
      check("plan.lhu_16", rd, 32'h0000_8899);
      run_req("sb_15", 1, 2'b00, 0, 32'h15, 32'h0, 32'h1234_565A, rd, ft);
      check("plan.sb_15_wdata", last_wr_data, 32'h8899_5ABB);
      check("plan.sb_15_addr", last_wr_addr, 32'd5);
      run_req("lw_14", 0, 2'b10, 0, 32'h14, 32'h0, 0, rd, ft);
      check("plan.lw_14", rd, 32'h8899_5ABB);
      run_req("lw_mis", 0, 2'b10, 0, 32'h12, 32'h0, 0, rd, ft);
      check("plan.lw_mis", ft, 1);
      run_req("lw_oob", 0, 2'b10, 0, 32'h1000, 32'h0, 0, rd, ft);
      check("plan.lw_oob", ft, 1);
      run_req("rsvd", 0, 2'b11, 0, 32'h14, 32'h0, 0, rd, ft);
      check("plan.rsvd", ft, 1);
      run_req("sw_wrap", 1, 2'b10, 0, 32'hFFFF_FFF0, 32'h30, 32'hDEAD_BEEF, rd, ft);
      check("plan.sw_wrap", mem[8], 32'hDEAD_BEEF);

      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_base = 32'h14; bus.req_offset = 32'h0;
      @(posedge clk);
      #1;
      bus.req_size = 2'b00; bus.req_unsigned = 1'b1; bus.req_base = 32'h20; bus.req_offset = 32'h3;
      check("b2b.ready_access", bus.req_ready, 0);
      @(posedge clk);
      #1;
      check("b2b.resp_a", bus.resp_valid, 1);
      check("b2b.rdata_a", bus.resp_rdata, ref_load(32'h14, 2'b10, 0));
      check("b2b.ready_resp", bus.req_ready, 0);
      @(posedge clk);
      #1;
      check("b2b.ready_idle", bus.req_ready, 1);
      check("b2b.gap", bus.resp_valid, 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("b2b.accept_b", bus.mem_read, 1);
      @(posedge clk);
      #1;
      check("b2b.resp_b", bus.resp_valid, 1);
      check("b2b.rdata_b", bus.resp_rdata, ref_load(32'h23, 2'b00, 1));
      @(posedge clk);
      #1;

      old = mem[9];
      wr0 = wr_count;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b00;
      bus.req_base = 32'h25; bus.req_offset = 32'h0; bus.req_wdata = 32'h77;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rstw.in_write", bus.mem_write, 1);
      reset = 1'b1;
      #1;
      check("rstw.ready", bus.req_ready, 0);
      check("rstw.resp", {bus.resp_valid, bus.resp_fault, bus.resp_rdata}, 0);
      check("rstw.mem", {bus.mem_read, bus.mem_write, bus.mem_address}, 0);
      check("rstw.wdata", bus.mem_write_data, 0);
      @(posedge clk);
      #1;
      check("rstw.no_write", wr_count - wr0, 0);
      check("rstw.word", mem[9], old);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstw.ready_rel", bus.req_ready, 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("rstw.no_resp", bus.resp_valid, 0);
      end

      for (int k = 0; k < 60; k++) begin
         logic [1:0]  sz;
         logic [31:0] base;
         logic [31:0] idx;
         idx = (($urandom % 8) == 0) ? 32'(1024 + $urandom_range(0, 5000)) : 32'($urandom_range(0, 1023));
         sz  = 2'($urandom_range(0, 3));
         ea  = (idx << 2) + 32'($urandom_range(0, 3));
         if (($urandom % 2) == 0 && sz != 2'b11)
            ea = ea & ~((32'd1 << sz) - 1);
         base = $urandom;
         run_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 base, ea - base, $urandom, rd, ft);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and computes the effective address.
- Drives the memory's address, read and write controls; performs read-modify-write for byte/halfword stores.
- Returns aligned, sign/zero-extended load data to writeback along with a fault flag.

Parameters:
size, 32, data and address width in bits
MemSize, 1024, number of words in data memory; valid word indices 0..MemSize-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0
req_base  input  size  base register value
req_offset  input  size  sign-extended immediate
req_wdata  input  size  store data; low byte/half used for sub-word stores
resp_valid  output  1  one-cycle pulse: response available
resp_rdata  output  size  load result; 0 for stores and faults
resp_fault  output  1  qualifies resp_valid; misaligned, out-of-range or reserved size
mem_address  output  size  word index to memory (ea >> 2)
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable, sampled by memory on rising clk
mem_write_data  output  size  word written to memory
mem_read_data  input  size  combinational read data from memory at mem_address

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. Reset forces IDLE asynchronously.
- Reset values: all outputs 0; req_ready is 0 while reset is asserted, then 1.
- Handshake: transfer on a rising edge with state==IDLE and req_valid. All request fields are latched at that edge; ea = req_base + req_offset, modulo 2^32.
- Fault check at acceptance, on any one of:
  - req_size==11;
  - halfword with ea[0]!=0;
  - word with ea[1:0]!=0;
  - ea[31:2] >= MemSize.
  A faulting request goes to RESP directly. mem_read and mem_write are never asserted for it.
- ACCESS (exactly one cycle):
  - mem_address = ea[31:2], mem_read = 1.
  - Word store: mem_write = 1 and mem_write_data = wdata in this cycle; next state RESP.
  - Load: latch the extracted, extended result from mem_read_data at the end of the cycle; next state RESP.
  - Sub-word store: latch mem_read_data as the old word; next state WRITE.
- WRITE (one cycle): mem_address held, mem_read = 0, mem_write = 1. mem_write_data is the old word with the selected lane replaced; all other lanes unchanged. Next state RESP.
- Lane rules (little-endian):
  - Byte lane n = ea[1:0] occupies bits [8n+7:8n].
  - Halfword lane ea[1] occupies bits [16*ea[1]+15 : 16*ea[1]].
  - Signed loads replicate the lane's MSB into the upper bits.
- RESP (one cycle): resp_valid = 1, resp_rdata/resp_fault driven; next state IDLE. resp_rdata and resp_fault hold until the next response. A new request is accepted one cycle after RESP.
- Latency from accept edge to resp_valid high:
  - fault: 1 cycle;
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles.
- Outside ACCESS/WRITE: mem_read = mem_write = 0, mem_address = 0, mem_write_data = 0.
- There is no back-pressure on the response. Writeback must take resp_valid in the cycle it is high.
- Reset mid-operation:
  - the operation is abandoned and no response is issued;
  - a write is suppressed if reset asserts before the write edge;
  - memory contents already written are not restored.

Test Plan:
- Preload word 5 = 0x8899AABB. Signed byte load, base 0x10 offset 0x7 (ea 0x17) -> resp_rdata 0xFFFFFF88, resp_fault 0, resp_valid 2 cycles after accept.
- Unsigned byte load at ea 0x16 -> 0x00000099. Signed half load at ea 0x14 -> 0xFFFFAABB. Unsigned half load at ea 0x16 -> 0x00008899.
- Byte store of 0x5A at ea 0x15 -> mem_write pulses once with mem_address 5 and mem_write_data 0x88995ABB. resp_valid 3 cycles after accept; subsequent word load of 0x14 -> 0x88995ABB.
- Word load at ea 0x12 -> resp_fault 1, resp_rdata 0 one cycle after accept. Word load at ea 0x1000 (index 1024) -> fault. req_size 11 -> fault. In all three cases mem_read and mem_write stay 0.
- Word store 0xDEADBEEF at base 0xFFFFFFF0 offset 0x30 (wraps to ea 0x20) -> memory word 8 = 0xDEADBEEF. Back-to-back req_valid: second request accepted the cycle after RESP, req_ready low during ACCESS/WRITE/RESP.
- Assert reset during WRITE of a byte store -> no mem_write edge occurs, target word unchanged, no resp_valid, all outputs 0, req_ready 1 after reset release.
